// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC blocks of the network controller:
// receiver state encoding and the default CRC-8 geometry.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } state_e;

  localparam int unsigned CRC_W_DEFAULT = 8;
  localparam logic [7:0]  POLY_DEFAULT  = 8'h07;

endpackage

// File: rtl/crc_bit_counter.sv
// Modulo counter with a runtime terminal value, used by the serial CRC
// receiver to track bit position in both the payload and check phases.
module crc_bit_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             rollover
);

  logic [CNT_W-1:0] count_q, count_d;

  // limit holds k-1, so the count runs 0..k-1 and wraps on the enabled step at k-1.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rollover = en && (count_q == limit);
    count_d  = count_q;
    if (clr || rollover) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/crc8_serial_checker.sv
// Bit-serial CRC receiver: after Start, shifts in DATA_BITS payload bits and
// CRC_W check bits MSB first, then publishes the payload and a zero-remainder flag.
module crc8_serial_checker
  import crc_pkg::*;
#(
  parameter int unsigned         DATA_BITS = 16,
  parameter int unsigned         CRC_W     = CRC_W_DEFAULT,
  parameter logic [CRC_W-1:0]    POLY      = CRC_W'(POLY_DEFAULT),
  parameter int unsigned         CNT_W     = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Din,
  input  logic                 DinValid,
  output logic [DATA_BITS-1:0] DataOut,
  output logic                 FrameDone,
  output logic                 CrcOk,
  output logic                 Busy
);

  state_e                 state_q, state_d;
  logic [CRC_W-1:0]       crc_q, crc_d, crc_step;
  logic [DATA_BITS-1:0]   payload_q, payload_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   crc_ok_q, crc_ok_d;
  logic                   frame_done_q, frame_done_d;
  logic                   sample, rollover, done, fb;
  logic [CNT_W-1:0]       limit;

  crc_bit_counter #(
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr      (Start),
    .en       (sample),
    .limit    (limit),
    .rollover (rollover)
  );

  always_comb begin
    // Start takes priority over any bit offered in the same cycle, including the last CRC bit.
    sample   = DinValid && !Start && (state_q != ST_IDLE);
    limit    = (state_q == ST_CRC) ? CNT_W'(CRC_W - 1) : CNT_W'(DATA_BITS - 1);
    fb       = crc_q[CRC_W-1] ^ Din;
    crc_step = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    done     = sample && rollover && (state_q == ST_CRC);

    state_d      = state_q;
    crc_d        = crc_q;
    payload_d    = payload_q;
    data_out_d   = data_out_q;
    crc_ok_d     = crc_ok_q;
    frame_done_d = done;

    if (Start) begin
      state_d   = ST_DATA;
      crc_d     = '0;
      payload_d = '0;
    end else if (sample) begin
      crc_d = crc_step;
      unique case (state_q)
        ST_DATA: begin
          payload_d = (payload_q << 1) | DATA_BITS'(Din);
          if (rollover) state_d = ST_CRC;
        end
        ST_CRC: begin
          if (rollover) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Published results survive Start and aborts; only a completed frame replaces them.
    if (done) begin
      data_out_d = payload_q;
      crc_ok_d   = (crc_step == '0);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      crc_q        <= '0;
      payload_q    <= '0;
      data_out_q   <= '0;
      crc_ok_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      payload_q    <= payload_d;
      data_out_q   <= data_out_d;
      crc_ok_q     <= crc_ok_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign DataOut   = data_out_q;
  assign CrcOk     = crc_ok_q;
  assign FrameDone = frame_done_q;
  assign Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crc8_serial_checker.sv
// Directed bench for crc8_serial_checker: a table of hand-computed CRC-8 frames
// plus sequences for abort, Start on the last bit, reset mid-frame and back-to-back.
module tb_crc8_serial_checker;

  logic        Clk = 1'b0;
  logic        Reset, Start, Din, DinValid;
  logic [15:0] DataOut;
  logic        FrameDone, CrcOk, Busy;

  crc8_serial_checker dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Din       (Din),
    .DinValid  (DinValid),
    .DataOut   (DataOut),
    .FrameDone (FrameDone),
    .CrcOk     (CrcOk),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  int total = 0;
  int bad = 0;
  bit busy_err = 0;

  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) if (FrameDone === 1'b1) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [15:0] payload;
    logic [7:0]  crc;
    bit          gapped;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Din/DinValid are high in the Start cycle to show that bit is ignored.
  task automatic start_frame();
    Start     = 1'b1;
    Din       = 1'b1;
    DinValid  = 1'b1;
    start_cyc = cyc;
    step();
    Start    = 1'b0;
    DinValid = 1'b0;
    busy_err = 1'b0;
  endtask

  task automatic drive_bits(input logic [23:0] bits, input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      if (Busy !== 1'b1) busy_err = 1'b1;
      Din      = bits[23-i];
      DinValid = 1'b1;
      step();
      if (gapped && i < n - 1) begin
        if (Busy !== 1'b1) busy_err = 1'b1;
        Din      = ~Din;
        DinValid = 1'b0;
        step();
      end
    end
    DinValid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (FrameDone === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, "_latency"}, 32'(cyc - start_cyc), 32'(exp_lat));
      check({name, "_busy_low_at_done"}, 32'(Busy), 32'd0);
    end
  endtask

  task automatic finish_frame(input logic [15:0] payload, input logic [7:0] crc, input bit gapped,
                              input logic exp_ok, input string name);
    drive_bits({payload, crc}, 24, gapped);
    check({name, "_busy_during"}, 32'(busy_err), 32'd0);
    wait_done(name, gapped ? 48 : 25);
    check({name, "_data_out"}, 32'(DataOut), 32'(payload));
    check({name, "_crc_ok"}, 32'(CrcOk), 32'(exp_ok));
  endtask

  task automatic run_frame(input logic [15:0] payload, input logic [7:0] crc, input bit gapped,
                           input logic exp_ok, input string name);
    start_frame();
    finish_frame(payload, crc, gapped, exp_ok, name);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;

    // CRC-8 poly 0x07, init 0, MSB first: remainders computed by hand.
    vecs[0] = '{16'h0001, 8'h07, 1'b0, 1'b1};
    vecs[1] = '{16'h0001, 8'h06, 1'b0, 1'b0};
    vecs[2] = '{16'h0001, 8'h07, 1'b1, 1'b1};
    vecs[3] = '{16'h0100, 8'h15, 1'b0, 1'b1};
    vecs[4] = '{16'h0080, 8'h89, 1'b0, 1'b1};
    vecs[5] = '{16'h0080, 8'h88, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 8'h01, 1'b0, 1'b0};

    Reset = 1'b0; Start = 1'b0; Din = 1'b0; DinValid = 1'b0;
    #12;
    check("reset_data_out", 32'(DataOut), 32'd0);
    check("reset_crc_ok", 32'(CrcOk), 32'd0);
    check("reset_frame_done", 32'(FrameDone), 32'd0);
    check("reset_busy", 32'(Busy), 32'd0);
    Reset = 1'b1;
    step();

    // Valid bits in IDLE without Start must be ignored.
    Din = 1'b1; DinValid = 1'b1;
    step(); step(); step();
    DinValid = 1'b0;
    check("idle_busy", 32'(Busy), 32'd0);
    check("idle_frame_done", 32'(FrameDone), 32'd0);

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].payload, vecs[v].crc, vecs[v].gapped, vecs[v].exp_ok, $sformatf("vec%0d", v));
      step();
      check($sformatf("vec%0d_pulse_end", v), 32'(FrameDone), 32'd0);
      check($sformatf("vec%0d_busy_after", v), 32'(Busy), 32'd0);
    end

    // Abort after 10 payload bits, then a full good frame: one FrameDone only.
    d0 = done_cnt;
    start_frame();
    drive_bits(24'h000107, 10, 1'b0);
    run_frame(16'h0001, 8'h07, 1'b0, 1'b1, "abort");
    step();
    check("abort_done_count", 32'(done_cnt - d0), 32'd1);

    // Start coinciding with the last CRC bit aborts without publishing.
    run_frame(16'h0100, 8'h15, 1'b0, 1'b1, "pre_last");
    step();
    start_frame();
    drive_bits(24'h008088, 23, 1'b0);
    Din = 1'b0;
    start_frame();
    check("last_bit_abort_no_done", 32'(FrameDone), 32'd0);
    check("last_bit_abort_data_hold", 32'(DataOut), 32'h0100);
    check("last_bit_abort_ok_hold", 32'(CrcOk), 32'd1);
    check("last_bit_abort_busy", 32'(Busy), 32'd1);
    finish_frame(16'h0080, 8'h89, 1'b0, 1'b1, "after_last_abort");
    step();

    // Asynchronous reset during the CRC phase clears everything at once.
    start_frame();
    drive_bits(24'h000107, 20, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    check("midreset_data_out", 32'(DataOut), 32'd0);
    check("midreset_crc_ok", 32'(CrcOk), 32'd0);
    check("midreset_busy", 32'(Busy), 32'd0);
    check("midreset_frame_done", 32'(FrameDone), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    step();
    run_frame(16'h0001, 8'h07, 1'b0, 1'b1, "post_reset");
    step();

    // Back-to-back: Start issued in the FrameDone cycle of the previous frame.
    run_frame(16'h0100, 8'h15, 1'b0, 1'b1, "b2b_first");
    start_frame();
    check("b2b_pulse_end", 32'(FrameDone), 32'd0);
    check("b2b_first_data_kept", 32'(DataOut), 32'h0100);
    check("b2b_busy", 32'(Busy), 32'd1);
    finish_frame(16'h0000, 8'h00, 1'b0, 1'b1, "b2b_second");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
